// File: rtl/pipe_stage_hs.sv
// -----------------------------------------------------------------------------
// pipe_stage_hs
//
// Parametrised pipeline register stage carrying an opaque WIDTH-bit payload
// with a valid/ready handshake. One instance per stage boundary.
//
// Features:
//   - EN freezes all state (no handshake, no counter updates).
//   - flush kills every held entry and counts the killed beats.
//   - stall_cnt / kill_cnt are saturating counters, cleared only by RST.
//   - out_data shows BUBBLE whenever the stage is empty.
//
// Optional build macro:
//   PIPE_STAGE_HS_SKID_EN - adds a second (skid) entry. in_ready then depends
//                           only on registered state, breaking the ready path
//                           from out_ready back to in_ready.
//
// Ports:
//   CLK        in   clock, rising edge
//   RST        in   synchronous reset, active-high
//   EN         in   stage enable, 0 freezes the stage
//   flush      in   synchronous kill of all held entries
//   in_valid   in   upstream has a beat
//   in_ready   out  stage accepts the beat this cycle
//   in_data    in   upstream payload [WIDTH]
//   out_valid  out  stage holds a beat
//   out_ready  in   downstream accepts
//   out_data   out  head payload, or BUBBLE when empty [WIDTH]
//   stall_cnt  out  saturating count of back-pressured cycles [CNT_W]
//   kill_cnt   out  saturating count of beats killed by flush [CNT_W]
// -----------------------------------------------------------------------------
module pipe_stage_hs #(
  parameter int               WIDTH  = 32,
  parameter logic [WIDTH-1:0] BUBBLE = '0,
  parameter int               CNT_W  = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] kill_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

`ifdef PIPE_STAGE_HS_SKID_EN
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FULL  = 2'd1,
    S_SKID  = 2'd2
  } state_e;
`else
  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_e;
`endif

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] head_q;
  logic             skid_valid;
  logic             accept;
  logic             rel_beat;
  logic             stall_inc;
  logic [1:0]       kill_add;
  logic [CNT_W:0]   kill_sum;

  // ---------------------------------------------------------------------------
  // Output decode from the state register
  // ---------------------------------------------------------------------------
  always_comb begin
    out_valid = (state_q != S_EMPTY);
`ifdef PIPE_STAGE_HS_SKID_EN
    skid_valid = (state_q == S_SKID);
    // Ready is a function of held state only; out_ready does not reach it.
    in_ready   = !RST && EN && !flush && !skid_valid;
`else
    skid_valid = 1'b0;
    // A full stage can still take a beat when the head leaves this cycle.
    in_ready   = !RST && EN && !flush && (!out_valid || out_ready);
`endif
  end

  assign accept   = in_valid && in_ready;
  assign rel_beat = out_valid && out_ready && EN && !flush;
  assign out_data = head_q;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    if (flush) begin
      state_d = S_EMPTY;
    end else if (EN) begin
      case (state_q)
        S_EMPTY: if (accept) state_d = S_FULL;
`ifdef PIPE_STAGE_HS_SKID_EN
        S_FULL: begin
          if (accept && !rel_beat)      state_d = S_SKID;
          else if (rel_beat && !accept) state_d = S_EMPTY;
        end
        S_SKID: if (rel_beat) state_d = S_FULL;
`else
        S_FULL: if (rel_beat && !accept) state_d = S_EMPTY;
`endif
        default: state_d = S_EMPTY;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State register (RST has priority over flush, which the next-state logic
  // already gives priority over EN)
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments for all clocked state, so every register
    // samples the pre-edge values regardless of block ordering.
    if (RST) state_q <= S_EMPTY;
    else     state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Payload registers
  // ---------------------------------------------------------------------------
`ifdef PIPE_STAGE_HS_SKID_EN
  logic [WIDTH-1:0] skid_q;

  // NOTE: the skid payload has no reset; it is only observed after being
  // written, because skid_valid (in state_q) gates every use of it.
  always_ff @(posedge CLK) begin
    if (state_q == S_FULL && accept && !rel_beat) skid_q <= in_data;
  end
`endif

  // The head register holds BUBBLE whenever the stage is empty, so out_data
  // needs no output mux and has no path from in_data.
  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      head_q <= BUBBLE;
    end else if (EN) begin
`ifdef PIPE_STAGE_HS_SKID_EN
      case (state_q)
        S_EMPTY: if (accept) head_q <= in_data;
        S_FULL:  if (rel_beat) head_q <= accept ? in_data : BUBBLE;
        S_SKID:  if (rel_beat) head_q <= skid_q;
        default: head_q <= BUBBLE;
      endcase
`else
      if (accept)        head_q <= in_data;
      else if (rel_beat) head_q <= BUBBLE;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating counters
  // ---------------------------------------------------------------------------
  assign stall_inc = EN && !flush && out_valid && !out_ready;
  assign kill_add  = {1'b0, out_valid} + {1'b0, skid_valid};
  // One extra bit catches the overflow of adding up to two killed beats.
  assign kill_sum  = {1'b0, kill_cnt} + (CNT_W+1)'(kill_add);

  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt <= '0;
      kill_cnt  <= '0;
    end else begin
      if (flush) begin
        kill_cnt <= kill_sum[CNT_W] ? CNT_MAX : kill_sum[CNT_W-1:0];
      end
      if (stall_inc && stall_cnt != CNT_MAX) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_hs.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_hs
//
// Testbench for pipe_stage_hs. Two instances share all inputs: a main one
// (CNT_W=16) and a narrow one (CNT_W=2) for counter saturation. Phases:
// table-driven stream/freeze rows, hand-written back-pressure, flush and
// reset-over-flush sequences, then a randomized run checked every cycle
// against a queue-based reference model. Honors PIPE_STAGE_HS_SKID_EN.
// -----------------------------------------------------------------------------
module tb_pipe_stage_hs;

  localparam int         W      = 8;
  localparam logic [7:0] BUB    = 8'hEE;
`ifdef PIPE_STAGE_HS_SKID_EN
  localparam bit         SKID   = 1'b1;
`else
  localparam bit         SKID   = 1'b0;
`endif
  localparam int         N_RAND = 1500;

  logic         CLK;
  logic         RST, EN, flush, in_valid, out_ready;
  logic [W-1:0] in_data;

  logic         in_ready, out_valid;
  logic [W-1:0] out_data;
  logic [15:0]  stall_cnt, kill_cnt;

  logic         s_in_ready, s_out_valid;
  logic [W-1:0] s_out_data;
  logic [1:0]   s_stall_cnt, s_kill_cnt;

  pipe_stage_hs #(.WIDTH(W), .BUBBLE(BUB), .CNT_W(16)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .stall_cnt(stall_cnt), .kill_cnt(kill_cnt)
  );

  pipe_stage_hs #(.WIDTH(W), .BUBBLE(BUB), .CNT_W(2)) dut_sat (
    .CLK(CLK), .RST(RST), .EN(EN), .flush(flush),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .stall_cnt(s_stall_cnt), .kill_cnt(s_kill_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a FIFO of at most 1 (or 2 with skid) beats, plus plain
  // integer counters clamped to each instance's range when compared.
  // ---------------------------------------------------------------------------
  logic [W-1:0] mq[$];
  int           stall_m = 0;
  int           kill_m  = 0;
  bit           last_acc = 1'b0;

  function automatic bit model_in_ready();
    if (RST || !EN || flush) return 1'b0;
    if (SKID) return mq.size() < 2;
    return (mq.size() == 0) || out_ready;
  endfunction

  function automatic int clamp(input int v, input int max);
    return (v > max) ? max : v;
  endfunction

  task automatic model_update();
    bit acc;
    acc = in_valid && model_in_ready();
    if (RST) begin
      mq.delete();
      stall_m = 0;
      kill_m  = 0;
    end else if (flush) begin
      kill_m += mq.size();
      mq.delete();
    end else if (EN) begin
      if (mq.size() > 0 && !out_ready) stall_m++;
      if (mq.size() > 0 && out_ready) void'(mq.pop_front());
      if (acc) mq.push_back(in_data);
    end
    last_acc = acc;
  endtask

  task automatic model_check();
    logic [W-1:0] exp_od;
    exp_od = (mq.size() > 0) ? mq[0] : BUB;
    check("rnd_in_ready",  in_ready,  model_in_ready());
    check("rnd_out_valid", out_valid, mq.size() > 0);
    check("rnd_out_data",  out_data,  exp_od);
    check("rnd_stall",     stall_cnt, clamp(stall_m, 65535));
    check("rnd_kill",      kill_cnt,  clamp(kill_m, 65535));
    check("rnd_sat_stall", s_stall_cnt, clamp(stall_m, 3));
    check("rnd_sat_kill",  s_kill_cnt,  clamp(kill_m, 3));
  endtask

  // Advance one clock: update the model with this cycle's inputs, then drive
  // the next inputs 1 time unit after the edge.
  task automatic adv();
    model_update();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_in(input logic rst, input logic en, input logic fl,
                        input logic iv, input logic [W-1:0] d, input logic ordy);
    RST = rst; EN = en; flush = fl; in_valid = iv; in_data = d; out_ready = ordy;
  endtask

  // ---------------------------------------------------------------------------
  // Table vectors: outputs expected at the negedge of the row's cycle
  // ---------------------------------------------------------------------------
  typedef struct {
    logic       rst, en, fl, iv;
    logic [7:0] d;
    logic       ordy;
    logic       e_ir, e_ov;
    logic [7:0] e_od;
    int         e_stall, e_kill;
  } vec_t;

  vec_t tbl[12];

  initial begin
    //            rst en fl iv  d      ordy  ir ov od     stall kill
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 8'hEE, 0, 0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 8'hEE, 0, 0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 8'h11, 0, 0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 8'h22, 0, 0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h33, 0, 0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'hEE, 0, 0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h55, 1'b1, 1'b1, 1'b0, 8'hEE, 0, 0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h66, 1'b1, 1'b0, 1'b1, 8'h55, 0, 0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h66, 1'b1, 1'b0, 1'b1, 8'h55, 0, 0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h66, 1'b1, 1'b0, 1'b1, 8'h55, 0, 0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h55, 0, 0};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'hEE, 0, 0};

    set_in(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    adv();

    // ---- stream and freeze ---------------------------------------------------
    for (int i = 0; i < 12; i++) begin
      set_in(tbl[i].rst, tbl[i].en, tbl[i].fl, tbl[i].iv, tbl[i].d, tbl[i].ordy);
      @(negedge CLK);
      check($sformatf("tbl%0d_in_ready", i),  in_ready,  tbl[i].e_ir);
      check($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].e_ov);
      check($sformatf("tbl%0d_out_data", i),  out_data,  tbl[i].e_od);
      check($sformatf("tbl%0d_stall", i),     stall_cnt, tbl[i].e_stall);
      check($sformatf("tbl%0d_kill", i),      kill_cnt,  tbl[i].e_kill);
      adv();
    end

    // ---- back-pressure: AA at head, out_ready low for 5 cycles ---------------
    set_in(1'b0, 1'b1, 1'b0, 1'b1, 8'hAA, 1'b0);
    @(negedge CLK);
    check("bp_accept_ready", in_ready, 1'b1);
    adv();
    set_in(1'b0, 1'b1, 1'b0, 1'b1, 8'hBB, 1'b0);
    @(negedge CLK);
    check("bp_head_first", out_data, 8'hAA);
    check("bp_ready_first", in_ready, SKID ? 1'b1 : 1'b0);
    adv();
    for (int c = 2; c <= 5; c++) begin
      set_in(1'b0, 1'b1, 1'b0, SKID ? 1'b0 : 1'b1, 8'hBB, 1'b0);
      @(negedge CLK);
      check($sformatf("bp_head_c%0d", c), out_data, 8'hAA);
      check($sformatf("bp_ready_c%0d", c), in_ready, 1'b0);
      if (c == 4) check("sat_stall_reach", s_stall_cnt, 2'd3);
      adv();
    end
    set_in(1'b0, 1'b1, 1'b0, SKID ? 1'b0 : 1'b1, 8'hBB, 1'b1);
    @(negedge CLK);
    check("bp_release_head", out_data, 8'hAA);
    check("bp_stall5", stall_cnt, 16'd5);
    check("sat_stall_hold", s_stall_cnt, 2'd3);
    check("bp_release_ready", in_ready, SKID ? 1'b0 : 1'b1);
    adv();
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    @(negedge CLK);
    check("bp_second_valid", out_valid, 1'b1);
    check("bp_second_data", out_data, 8'hBB);
    adv();
    @(negedge CLK);
    check("bp_drained_valid", out_valid, 1'b0);
    check("bp_drained_data", out_data, BUB);
    check("bp_stall_final", stall_cnt, 16'd5);
    adv();

    // ---- flush: 77 at head (plus 88 in skid) ----------------------------------
    set_in(1'b0, 1'b1, 1'b0, 1'b1, 8'h77, 1'b0);
    @(negedge CLK);
    adv();
    if (SKID) begin
      set_in(1'b0, 1'b1, 1'b0, 1'b1, 8'h88, 1'b0);
      @(negedge CLK);
      check("fl_skid_accept", in_ready, 1'b1);
      adv();
    end
    set_in(1'b0, 1'b1, 1'b1, 1'b1, 8'h99, 1'b0);
    @(negedge CLK);
    check("fl_ready", in_ready, 1'b0);
    check("fl_head_before", out_data, 8'h77);
    adv();
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    @(negedge CLK);
    check("fl_valid_after", out_valid, 1'b0);
    check("fl_data_after", out_data, BUB);
    check("fl_kill", kill_cnt, SKID ? 16'd2 : 16'd1);
    adv();

    // flush overrides EN=0
    set_in(1'b0, 1'b1, 1'b0, 1'b1, 8'h42, 1'b0);
    @(negedge CLK);
    adv();
    set_in(1'b0, 1'b0, 1'b1, 1'b1, 8'h43, 1'b0);
    @(negedge CLK);
    check("fl_en0_ready", in_ready, 1'b0);
    adv();
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    @(negedge CLK);
    check("fl_en0_valid", out_valid, 1'b0);
    check("fl_en0_kill", kill_cnt, SKID ? 16'd3 : 16'd2);
    adv();

    // ---- reset beats flush ----------------------------------------------------
    set_in(1'b0, 1'b1, 1'b0, 1'b1, 8'h12, 1'b0);
    @(negedge CLK);
    adv();
    if (SKID) begin
      set_in(1'b0, 1'b1, 1'b0, 1'b1, 8'h34, 1'b0);
      @(negedge CLK);
      adv();
    end
    set_in(1'b1, 1'b1, 1'b1, 1'b1, 8'h56, 1'b0);
    @(negedge CLK);
    check("rf_ready", in_ready, 1'b0);
    adv();
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    @(negedge CLK);
    check("rf_valid", out_valid, 1'b0);
    check("rf_data", out_data, BUB);
    check("rf_kill", kill_cnt, 16'd0);
    check("rf_stall", stall_cnt, 16'd0);
    check("rf_sat_kill", s_kill_cnt, 2'd0);
    adv();

    // ---- randomized run against the model -------------------------------------
    for (int n = 0; n < N_RAND; n++) begin
      logic iv_n;
      logic [W-1:0] d_n;
      // Upstream holds an unaccepted beat stable.
      if (in_valid && !last_acc) begin
        iv_n = 1'b1;
        d_n  = in_data;
      end else begin
        iv_n = ($urandom_range(0, 3) != 0);
        d_n  = W'($urandom);
      end
      set_in(($urandom_range(0, 99) == 0),
             ($urandom_range(0, 9) != 0),
             ($urandom_range(0, 29) == 0),
             iv_n, d_n,
             ($urandom_range(0, 2) != 0));
      @(negedge CLK);
      model_check();
      adv();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
